// File: rtl/pcpu_muldiv.sv
// pcpu_muldiv: iterative multiply / divide unit for the EX stage.
// Shift-add multiply or restoring divide, one bit per clock, with a
// start/busy/done handshake and a branch-kill flush.
// Optional feature macro: MULDIV_SIGNED_EN (honours signed_op when defined).
module pcpu_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic              signed_op,
    input  logic              flush,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic              zf,
    output logic              nf,
    output logic              dz
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return (~v) + DATA_W'(1'b1);
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return (~v) + (2*DATA_W)'(1'b1);
    endfunction

    state_t              state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W-1:0] acc_r;      // {hi, lo}: product accumulator or {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opnd_r;     // multiplicand (mul) or divisor (div) magnitude
    logic                op_r;
    logic                neg_p_r;    // product / quotient must be negated
    logic                neg_a_r;    // remainder must be negated
    logic                dz_pend_r;  // divide-by-zero accepted, DONE on the next edge
    logic                busy_r, done_r, zf_r, nf_r, dz_r;
    logic [DATA_W-1:0]   result_lo_r, result_hi_r;

    logic                sgn_s;
    logic                dz_s, accept_s, calc_last_s;
    logic                a_neg_s, b_neg_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s;
    logic [DATA_W:0]     mul_sum_s, div_rsh_s;
    logic [DATA_W+1:0]   div_diff_s;
    logic [2*DATA_W-1:0] step_s, prod_s;
    logic [DATA_W-1:0]   fin_lo_s, fin_hi_s;

`ifdef MULDIV_SIGNED_EN
    assign sgn_s = signed_op;
`else
    logic unused_signed_op_s;
    assign unused_signed_op_s = signed_op;
    assign sgn_s = 1'b0;
`endif

    assign dz_s        = op && (opb == {DATA_W{1'b0}});
    assign accept_s    = start && !flush && !dz_pend_r &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign calc_last_s = (state_r == ST_CALC) && (cnt_r == {CNT_W{1'b0}});
    assign a_neg_s     = sgn_s && opa[DATA_W-1];
    assign b_neg_s     = sgn_s && opb[DATA_W-1];
    assign a_mag_s     = a_neg_s ? neg_w(opa) : opa;
    assign b_mag_s     = b_neg_s ? neg_w(opb) : opb;

    // One iteration of the datapath plus the sign correction of its final value.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                     (acc_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
        div_rsh_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        div_diff_s = {1'b0, div_rsh_s} - {2'b00, opnd_r};
        if (op_r) begin
            if (!div_diff_s[DATA_W+1]) begin
                step_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
            end else begin
                step_s = {div_rsh_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end
        prod_s = neg_p_r ? neg_2w(step_s) : step_s;
        if (op_r) begin
            fin_lo_s = neg_p_r ? neg_w(step_s[DATA_W-1:0]) : step_s[DATA_W-1:0];
            fin_hi_s = neg_a_r ? neg_w(step_s[2*DATA_W-1:DATA_W]) : step_s[2*DATA_W-1:DATA_W];
        end else begin
            fin_lo_s = prod_s[DATA_W-1:0];
            fin_hi_s = prod_s[2*DATA_W-1:DATA_W];
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (dz_pend_r) begin
                    state_nx_s = ST_DONE;
                end else if (accept_s && !dz_s) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else if (calc_last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (accept_s && !dz_s) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_pend_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            busy_r    <= (state_nx_s == ST_CALC);
            done_r    <= (state_nx_s == ST_DONE);
            dz_pend_r <= accept_s && dz_s;
        end
    end

    // Operand capture on acceptance and one iteration per CALC cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {(2*DATA_W){1'b0}};
            opnd_r  <= {DATA_W{1'b0}};
            op_r    <= 1'b0;
            neg_p_r <= 1'b0;
            neg_a_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= CNT_LOAD;
            op_r    <= op;
            neg_p_r <= a_neg_s ^ b_neg_s;
            neg_a_r <= a_neg_s;
            if (dz_s) begin
                acc_r <= {{DATA_W{1'b0}}, opa};
            end else if (op) begin
                acc_r  <= {{DATA_W{1'b0}}, a_mag_s};
                opnd_r <= b_mag_s;
            end else begin
                acc_r  <= {{DATA_W{1'b0}}, b_mag_s};
                opnd_r <= a_mag_s;
            end
        end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
            acc_r <= step_s;
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_lo_r <= {DATA_W{1'b0}};
            result_hi_r <= {DATA_W{1'b0}};
            zf_r        <= 1'b0;
            nf_r        <= 1'b0;
            dz_r        <= 1'b0;
        end else if (calc_last_s && !flush) begin
            result_lo_r <= fin_lo_s;
            result_hi_r <= fin_hi_s;
            zf_r        <= (fin_lo_s == {DATA_W{1'b0}});
            nf_r        <= fin_lo_s[DATA_W-1];
            dz_r        <= 1'b0;
        end else if (dz_pend_r && !flush) begin
            result_lo_r <= {DATA_W{1'b1}};
            result_hi_r <= acc_r[DATA_W-1:0];
            zf_r        <= 1'b0;
            nf_r        <= 1'b1;
            dz_r        <= 1'b1;
        end else begin
            result_lo_r <= result_lo_r;
            result_hi_r <= result_hi_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result_lo = result_lo_r;
    assign result_hi = result_hi_r;
    assign zf        = zf_r;
    assign nf        = nf_r;
    assign dz        = dz_r;

endmodule

// File: tb/tb_pcpu_muldiv.sv
// Self-checking bench for pcpu_muldiv (DATA_W = 16) with a result scoreboard.
module tb_pcpu_muldiv;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         signed_op = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] opa = 16'h0000;
    logic [W-1:0] opb = 16'h0000;
    logic         busy, done, zf, nf, dz;
    logic [W-1:0] result_lo, result_hi;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_lo = 16'h0000;
    logic [15:0] last_hi = 16'h0000;
    logic        last_dz = 1'b0;
    int          smp, bcnt;

    pcpu_muldiv #(.DATA_W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .signed_op(signed_op), .flush(flush), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .zf(zf), .nf(nf), .dz(dz)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        int          qi, ri;
        logic        use_s;
`ifdef MULDIV_SIGNED_EN
        use_s = s;
`else
        use_s = s & 1'b0;
`endif
        e.dz = 1'b0;
        if (o && (b == 16'h0000)) begin
            e.lo = 16'hFFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (!o) begin
            if (use_s) p = 32'(int'($signed(a)) * int'($signed(b)));
            else       p = {16'h0000, a} * {16'h0000, b};
            e.lo = p[15:0];
            e.hi = p[31:16];
        end else begin
            if (use_s) begin
                qi = int'($signed(a)) / int'($signed(b));
                ri = int'($signed(a)) % int'($signed(b));
            end else begin
                qi = int'({16'h0000, a}) / int'({16'h0000, b});
                ri = int'({16'h0000, a}) % int'({16'h0000, b});
            end
            e.lo = qi[15:0];
            e.hi = ri[15:0];
        end
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("result_lo", 64'(result_lo), 64'(mon_e.lo));
                check_val("result_hi", 64'(result_hi), 64'(mon_e.hi));
                check_val("dz", 64'(dz), 64'(mon_e.dz));
                check_val("zf", 64'(zf), 64'(mon_e.lo == 16'h0000));
                check_val("nf", 64'(nf), 64'(mon_e.lo[15]));
                last_lo = mon_e.lo;
                last_hi = mon_e.hi;
                last_dz = mon_e.dz;
            end
        end
    end

    // Drive one request for a single clock edge; called at a negedge.
    task automatic issue(input logic o, input logic s, input logic [15:0] a, input logic [15:0] b, input bit push);
        start = 1'b1; op = o; signed_op = s; opa = a; opb = b;
        if (push) sb.push_back(model(o, s, a, b));
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int samples, output int busy_cnt);
        samples = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            samples++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        if (!done) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic o, input logic s, input logic [15:0] a, input logic [15:0] b);
        int sm, bc;
        bit is_dz;
        is_dz = o && (b == 16'h0000);
        repeat (2) @(negedge clock);
        issue(o, s, a, b, 1'b1);
        wait_done(sm, bc);
        check_val("latency", 64'(sm), is_dz ? 64'd2 : 64'd17);
        check_val("busy_cycles", 64'(bc), is_dz ? 64'd0 : 64'd16);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_val("reset_outputs", {27'd0, busy, done, zf, nf, dz, result_lo, result_hi}, 64'd0);
        reset = 1'b1;

        run_op(1'b0, 1'b0, 16'h1234, 16'h0010);
        @(negedge clock);
        check_val("done_single_pulse", 64'(done), 64'd0);
        check_val("mul_1234_hi", 64'(result_hi), 64'h0001);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        check_val("mul_ffff_lo", 64'(result_lo), 64'h0001);
        run_op(1'b1, 1'b0, 16'd100, 16'd7);
        check_val("div_100_7_lo", 64'(result_lo), 64'h000E);
        run_op(1'b1, 1'b0, 16'h1234, 16'h0000);
        check_val("div0_hi", 64'(result_hi), 64'h1234);

        // Flush mid-CALC: no done, results held.
        repeat (2) @(negedge clock);
        issue(1'b0, 1'b0, 16'h00AB, 16'h00CD, 1'b0);
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_val("flush_busy", 64'(busy), 64'd0);
        repeat (25) @(negedge clock);
        check_val("flush_hold", {31'd0, last_dz, last_hi, last_lo}, {31'd0, dz, result_hi, result_lo});

        // Start and flush together: request dropped.
        start = 1'b1; flush = 1'b1; op = 1'b0; opa = 16'd3; opb = 16'd4;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clock);
        check_val("start_flush_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clock);

        // Back-to-back: second start issued while done is high.
        run_op(1'b1, 1'b0, 16'd1000, 16'd33);
        issue(1'b0, 1'b0, 16'h0102, 16'h0304, 1'b1);
        wait_done(smp, bcnt);
        check_val("b2b_latency", 64'(smp), 64'd17);
        check_val("b2b_busy", 64'(bcnt), 64'd16);

        // Asynchronous reset mid-CALC.
        repeat (2) @(negedge clock);
        issue(1'b1, 1'b0, 16'hABCD, 16'h0003, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("reset_mid_calc", {27'd0, busy, done, zf, nf, dz, result_lo, result_hi}, 64'd0);
        last_lo = 16'h0000; last_hi = 16'h0000; last_dz = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // Signed-request cases; expectations follow the build configuration.
        run_op(1'b1, 1'b1, 16'hFFF9, 16'h0002);
`ifdef MULDIV_SIGNED_EN
        check_val("sdiv_const", {32'd0, result_hi, result_lo}, {32'd0, 16'hFFFF, 16'hFFFD});
`else
        check_val("sdiv_const", {32'd0, result_hi, result_lo}, {32'd0, 16'h0001, 16'h7FFC});
`endif
        run_op(1'b0, 1'b1, 16'hFFFD, 16'h0005);
        run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF);
        run_op(1'b1, 1'b1, 16'h0007, 16'hFFFE);
        run_op(1'b1, 1'b1, 16'h8001, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            logic        ro, rs;
            logic [15:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 12));
            run_op(ro, rs, ra, rb);
        end

        repeat (3) @(negedge clock);
        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
